// File: rtl/data_mem_responder.sv
// data_mem_responder: MEM-stage load/store target with a programmable wait-state count.
// It serves one request at a time from an internal word array, returns aligned and
// extended load data, and holds mem_stall until the access completes.
// Optional feature macro: DMEM_ALIGN_CHK_EN. When it is defined, misaligned half/word
// accesses are flagged on addr_err and perform no write. When it is undefined, the low
// address bits are forced aligned.
module data_mem_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        mem_stall,
  output logic        addr_err
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic [1:0]              size_q, size_d;
  logic                    sext_q, sext_d;
  logic [DEPTH_LOG2+1:0]   addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    ready_q, ready_d;
  logic                    err_q, err_d;

  logic [31:0]             mem_q [0:WORDS-1];

  logic [DEPTH_LOG2-1:0]   idx;
  logic [31:0]             word_rd;
  logic                    commit;
  logic                    misalign;
  logic                    wr_en;
  logic [3:0]              wr_mask;
  logic [31:0]             wr_data;
  logic                    unused_addr_hi;

  // Upper address bits only select aliases of the same word, so they are dropped.
  assign unused_addr_hi = ^addr[31:DEPTH_LOG2+2];

  // Byte lanes touched by a store of the given size at the given low address bits.
  function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] a);
    logic [3:0] m;
    case (sz)
      2'b00:   m = 4'b0001 << a;
      2'b01:   m = a[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Replicate right-justified store data across lanes so any selected lane sees it.
  function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] d;
    case (sz)
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  // Pick the addressed byte/half, move it to bit 0 and sign- or zero-extend it.
  function automatic logic [31:0] load_extract(input logic [1:0] sz, input logic [1:0] a,
                                               input logic sx, input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   r = {{24{sx & b[7]}}, b};
      2'b01:   r = {{16{sx & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  assign idx     = addr_q[DEPTH_LOG2+1:2];
  assign word_rd = mem_q[idx];
  assign commit  = (state_q == BUSY) && (cnt_q == 4'd0);
  assign wr_mask = lane_mask(size_q, addr_q[1:0]);
  assign wr_data = lane_data(size_q, wdata_q);

`ifdef DMEM_ALIGN_CHK_EN
  assign misalign = ((size_q == 2'b01) && addr_q[0]) ||
                    (size_q[1] && (addr_q[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // A store commits only on the final wait edge and never while reset is held.
  assign wr_en = commit && we_q && !misalign && rst;

  // Next-state logic: latch the request in IDLE, count wait states, respond for one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    sext_d  = sext_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    ready_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          size_d  = size;
          sext_d  = sext;
          addr_d  = addr[DEPTH_LOG2+1:0];
          wdata_d = wdata;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          ready_d = 1'b1;
          err_d   = misalign;
          rdata_d = (we_q || misalign) ? 32'd0
                                       : load_extract(size_q, addr_q[1:0], sext_q, word_rd);
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and response registers; an asserted reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      sext_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // Word array write port: only the selected byte lanes are updated.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_mask[i]) mem_q[idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  assign rdata     = rdata_q;
  assign ready     = ready_q;
  assign addr_err  = err_q;
  assign mem_stall = ((state_q == IDLE) && req) || (state_q == BUSY);

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a byte-addressed reference memory predicts
// each response when the request is issued; a monitor checks ready/mem_stall every cycle
// and pops the expected data when a response is due.
module tb_data_mem_responder;

  localparam int DEPTH_LOG2 = 10;
  localparam int WAIT       = 2;
  localparam int WORDS      = 1 << DEPTH_LOG2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sext = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        ready;
  logic        mem_stall;
  logic        addr_err;

  data_mem_responder #(.DEPTH_LOG2(DEPTH_LOG2), .WAIT_CYCLES(WAIT)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready),
    .mem_stall(mem_stall), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  bit   outstanding = 1'b0;
  int   exp_ready_cyc = 0;

  logic [7:0] ref_mem [0:4*WORDS-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: byte-addressed memory, access width 1/2/4 bytes.
  function automatic exp_t model(input bit w, input logic [1:0] sz, input bit sx,
                                 input logic [31:0] a, input logic [31:0] wd);
    exp_t        e;
    int          n;
    int          base;
    logic [31:0] al;
    logic [31:0] v;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    e.rdata = 32'd0;
    e.err   = 1'b0;
`ifdef DMEM_ALIGN_CHK_EN
    if ((a % n) != 0) begin
      e.err = 1'b1;
      return e;
    end
`endif
    al   = a - (a % n);
    base = int'(al % (4 * WORDS));
    if (w) begin
      for (int i = 0; i < n; i++) ref_mem[base + i] = wd[8*i +: 8];
      return e;
    end
    v = 32'd0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[base + i];
    if (sx && n < 4 && v[8*n - 1]) begin
      for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
    end
    e.rdata = v;
    return e;
  endfunction

  // Issue one access; fields are scrambled after acceptance to show they are latched.
  task automatic access(input bit w, input logic [1:0] sz, input bit sx,
                        input logic [31:0] a, input logic [31:0] wd);
    sb.push_back(model(w, sz, sx, a, wd));
    we = w; size = sz; sext = sx; addr = a; wdata = wd; req = 1'b1;
    exp_ready_cyc = cyc + WAIT + 2;
    outstanding   = 1'b1;
    @(posedge clk); #1;
    we = ~w; size = 2'($urandom); sext = ~sx; addr = $urandom; wdata = $urandom;
    repeat (WAIT + 2) @(posedge clk);
    #1;
    req = 1'b0;
    outstanding = 1'b0;
  endtask

  // Monitor: timing of ready/mem_stall every cycle, data checked when a response is present.
  always @(negedge clk) begin
    bit   er;
    exp_t e;
    er = outstanding && (cyc == exp_ready_cyc);
    check("ready", 32'(ready), 32'(er));
    check("mem_stall", 32'(mem_stall), 32'(outstanding && (cyc < exp_ready_cyc)));
    if (ready || er) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_empty at cycle %0d: got response rdata %h, expected none", cyc, rdata);
      end else begin
        e = sb.pop_front();
        check("rdata", rdata, e.rdata);
        check("addr_err", 32'(addr_err), 32'(e.err));
      end
    end
  end

  initial begin
    logic [31:0] ra;
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata", rdata, 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_addr_err", 32'(addr_err), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Preload a 256-byte window so every later load has a known value.
    for (int i = 0; i < 64; i++) access(1'b1, 2'b10, 1'b0, 32'(i * 4), $urandom);

    // Word store then load.
    access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
    // Byte store, signed/unsigned byte loads, word view of the lane.
    access(1'b1, 2'b00, 1'b0, 32'h21, 32'h00000080);
    access(1'b0, 2'b00, 1'b1, 32'h21, 32'd0);
    access(1'b0, 2'b00, 1'b0, 32'h21, 32'd0);
    access(1'b0, 2'b10, 1'b0, 32'h20, 32'd0);
    // Half store into upper half, word and signed half loads.
    access(1'b1, 2'b10, 1'b0, 32'h30, 32'h11223344);
    access(1'b1, 2'b01, 1'b0, 32'h32, 32'h0000ABCD);
    access(1'b0, 2'b10, 1'b0, 32'h30, 32'd0);
    access(1'b0, 2'b01, 1'b1, 32'h32, 32'd0);
    // Upper address bits alias back onto the same word; reserved size acts as word.
    access(1'b1, 2'b10, 1'b0, 32'h10 + 32'(1 << (DEPTH_LOG2 + 2)), 32'hCAFEF00D);
    access(1'b0, 2'b11, 1'b0, 32'h10, 32'd0);
    // Misaligned word load and half store, then observe the word.
    access(1'b0, 2'b10, 1'b0, 32'h42, 32'd0);
    access(1'b1, 2'b01, 1'b0, 32'h43, 32'h00007777);
    access(1'b0, 2'b10, 1'b0, 32'h40, 32'd0);

    // Reset during BUSY: the store must not land.
    we = 1'b1; size = 2'b10; sext = 1'b0; addr = 32'h40; wdata = 32'h55; req = 1'b1;
    exp_ready_cyc = cyc + WAIT + 2;
    outstanding   = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    outstanding = 1'b0;
    req = 1'b0;
    rst = 1'b0;
    #2;
    check("abort_ready", 32'(ready), 32'd0);
    check("abort_stall", 32'(mem_stall), 32'd0);
    check("abort_rdata", rdata, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    access(1'b0, 2'b10, 1'b0, 32'h40, 32'd0);

    // Randomized traffic within the preloaded window, with random upper bits.
    for (int k = 0; k < 400; k++) begin
      ra = {20'($urandom), 4'h0, 8'($urandom)};
      access(1'($urandom), 2'($urandom), 1'($urandom), ra, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
